// File: rtl/ifetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// ifetch_stage_pkg: bus widths, reset PC and FSM encodings for the IF stage
// Revision: 1.0
// ============================================================================
package ifetch_stage_pkg;

  localparam int IF_TO_IPD_BUS_WD = 96;
  localparam int ID_TO_IPD_BUS_WD = 33;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_REDIR = 2'd2
  } if_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage : ifetch_stage_pkg
`default_nettype wire

// File: rtl/ifetch_stage_perf_cnt.sv
`default_nettype none
// ============================================================================
// ifetch_perf_cnt: wrapping fire/redirect event counters for the IF stage
// Revision: 1.0
// ============================================================================
module ifetch_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire,
  input  logic        redirect,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt    <= 32'd0;
      redirect_cnt <= 32'd0;
    end else begin
      if (fire)     fetch_cnt    <= fetch_cnt + 32'd1;
      if (redirect) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

endmodule : ifetch_perf_cnt
`default_nettype wire

// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// ifetch_stage: fetch PC, inst RAM read strobe, IF->IPD handshake and redirects
// Counters built only when IFETCH_PERF_CNT_EN is defined. Revision: 1.0
// ============================================================================
module ifetch_stage
  import ifetch_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ID_TO_IPD_BUS_WD-1:0] ID_to_IPD_bus,
  input  logic                        IPD_allow_in,
  output logic                        IF_to_IPD_valid,
  output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
  output logic                        inst_ram_en,
  output logic [3:0]                  inst_ram_we,
  output logic [31:0]                 inst_ram_addr,
  output logic [31:0]                 inst_ram_wdata,
  output logic [31:0]                 fetch_cnt,
  output logic [31:0]                 redirect_cnt
);

  if_state_t   state;
  logic [31:0] pc;
  logic        br_taken_cancel;
  logic [31:0] redirect_pc;
  logic        fire;
  logic [1:0]  unused_id_lsbs;

  assign br_taken_cancel = ID_to_IPD_bus[32];
  assign redirect_pc     = word_align(ID_to_IPD_bus[31:0]);
  assign unused_id_lsbs  = ID_to_IPD_bus[1:0];

  // Cancel kills valid combinationally: IPD loads the bus ahead of its own flush.
  assign IF_to_IPD_valid = (state == ST_FETCH) && !br_taken_cancel;
  assign fire            = IF_to_IPD_valid && IPD_allow_in;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RST;
      pc    <= RESET_PC;
    end else begin
      case (state)
        ST_RST:   state <= ST_FETCH;
        ST_FETCH: state <= br_taken_cancel ? ST_REDIR : ST_FETCH;
        ST_REDIR: state <= br_taken_cancel ? ST_REDIR : ST_FETCH;
        default:  state <= ST_RST;
      endcase

      if (br_taken_cancel && (state != ST_RST)) begin
        pc <= redirect_pc;
      end else if (fire) begin
        pc <= seq_pc(pc);
      end
    end
  end

  // RAM is strobed only on fire so read data stays stable across IPD stalls.
  assign inst_ram_en    = fire;
  assign inst_ram_addr  = word_align(pc);
  assign inst_ram_we    = 4'b0000;
  assign inst_ram_wdata = 32'd0;
  assign IF_to_IPD_bus  = {seq_pc(pc), pc, 32'd0};

`ifdef IFETCH_PERF_CNT_EN
  logic redirect_applied;
  assign redirect_applied = br_taken_cancel && (state != ST_RST);

  ifetch_perf_cnt u_perf_cnt (
    .clk          (clk),
    .reset        (reset),
    .fire         (fire),
    .redirect     (redirect_applied),
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt)
  );
`else
  assign fetch_cnt    = 32'd0;
  assign redirect_cnt = 32'd0;
`endif

endmodule : ifetch_stage
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
// tb_ifetch_stage: scoreboard bench for ifetch_stage (fire addresses queued)
// Revision: 1.0
// ============================================================================
module tb_ifetch_stage;

`ifdef IFETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] RPC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [32:0] id_bus;
  logic        allow_in;
  logic        valid;
  logic [95:0] if_bus;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;

  int checks = 0;
  int passed = 0;
  bit mon_on = 1'b0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ifetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ID_to_IPD_bus   (id_bus),
    .IPD_allow_in    (allow_in),
    .IF_to_IPD_valid (valid),
    .IF_to_IPD_bus   (if_bus),
    .inst_ram_en     (ram_en),
    .inst_ram_we     (ram_we),
    .inst_ram_addr   (ram_addr),
    .inst_ram_wdata  (ram_wdata),
    .fetch_cnt       (fetch_cnt),
    .redirect_cnt    (redirect_cnt)
  );

  // Scoreboard: every RAM read strobe must match the next queued fetch address.
  always @(negedge clk) begin
    if (mon_on && ram_en !== 1'b0) begin
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_fire addr=%h expected no fire", ram_addr);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e || if_bus[95:64] !== e + 32'd4 || if_bus[63:32] !== e)
          $display("FAIL fire addr=%h pred=%h inst=%h expected addr=%h pred=%h",
                   ram_addr, if_bus[95:64], if_bus[63:32], e, e + 32'd4);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(base + 32'(4 * i));
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; allow_in = 1'b1; id_bus = '0;
    repeat (3) tick();
    mon_on = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || ram_en !== 1'b0 || ram_addr !== RPC || ram_we !== 4'b0 || ram_wdata !== 32'd0)
      $display("FAIL reset_outputs valid=%b en=%b addr=%h we=%h wd=%h expected 0,0,%h,0,0",
               valid, ram_en, ram_addr, ram_we, ram_wdata, RPC);
    else passed++;
    checks++;
    if (if_bus !== {RPC + 32'd4, RPC, 32'd0} || fetch_cnt !== 32'd0 || redirect_cnt !== 32'd0)
      $display("FAIL reset_bus bus=%h fc=%0d rc=%0d expected %h,0,0",
               if_bus, fetch_cnt, redirect_cnt, {RPC + 32'd4, RPC, 32'd0});
    else passed++;
    // release reset with a cancel pulse that must be ignored in RST
    reset = 1'b1; id_bus = {1'b1, 32'h1c00_0500};
    #1;
    checks++;
    if (valid !== 1'b0) $display("FAIL rst_state_valid got %b expected 0", valid);
    else passed++;
    tick();
    id_bus = '0;
    exp_q.push_back(RPC);
    #1;
    checks++;
    if (valid !== 1'b1 || ram_en !== 1'b1 || ram_addr !== RPC || if_bus[95:64] !== 32'h1c00_0004)
      $display("FAIL first_fetch valid=%b en=%b addr=%h pred=%h expected 1,1,%h,1c000004",
               valid, ram_en, ram_addr, if_bus[95:64], RPC);
    else passed++;
    checks++;
    if (redirect_cnt !== 32'd0) $display("FAIL rst_cancel_cnt got %0d expected 0", redirect_cnt);
    else passed++;
    tick();
    exp_q.push_back(32'h1c00_0004);
    #1;
    checks++;
    if (ram_addr !== 32'h1c00_0004) $display("FAIL second_fetch addr=%h expected 1c000004", ram_addr);
    else passed++;
    tick();
  endtask

  task automatic test_stall();
    allow_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ram_en !== 1'b0 || valid !== 1'b1 || ram_addr !== 32'h1c00_0008 ||
          if_bus !== {32'h1c00_000c, 32'h1c00_0008, 32'd0})
        $display("FAIL stall_hold cyc=%0d en=%b valid=%b addr=%h bus=%h expected 0,1,1c000008",
                 i, ram_en, valid, ram_addr, if_bus);
      else passed++;
      tick();
    end
    allow_in = 1'b1;
    exp_q.push_back(32'h1c00_0008);
    #1;
    checks++;
    if (ram_en !== 1'b1 || ram_addr !== 32'h1c00_0008)
      $display("FAIL stall_release en=%b addr=%h expected 1,1c000008", ram_en, ram_addr);
    else passed++;
    tick();
    exp_q.push_back(32'h1c00_000c);
    tick();
  endtask

  task automatic test_redirect();
    id_bus = {1'b1, 32'h1c00_0100};
    #1;
    checks++;
    if (valid !== 1'b0 || ram_en !== 1'b0 || ram_addr !== 32'h1c00_0010)
      $display("FAIL redirect_kill valid=%b en=%b addr=%h expected 0,0,1c000010", valid, ram_en, ram_addr);
    else passed++;
    tick();
    id_bus = '0;
    #1;
    checks++;
    if (valid !== 1'b0 || ram_en !== 1'b0)
      $display("FAIL redirect_bubble valid=%b en=%b expected 0,0", valid, ram_en);
    else passed++;
    tick();
    exp_q.push_back(32'h1c00_0100);
    #1;
    checks++;
    if (valid !== 1'b1 || ram_addr !== 32'h1c00_0100 || redirect_cnt !== 32'(PERF))
      $display("FAIL redirect_target valid=%b addr=%h rc=%0d expected 1,1c000100,%0d",
               valid, ram_addr, redirect_cnt, 32'(PERF));
    else passed++;
    tick();
  endtask

  task automatic test_cancel_stall_back_to_back();
    allow_in = 1'b0;
    id_bus = {1'b1, 32'h1c00_0200};
    tick();
    id_bus = {1'b1, 32'h1c00_0300};
    #1;
    checks++;
    if (valid !== 1'b0) $display("FAIL b2b_redir_valid got %b expected 0", valid);
    else passed++;
    tick();
    id_bus = '0;
    #1;
    checks++;
    if (valid !== 1'b0 || ram_en !== 1'b0)
      $display("FAIL b2b_second_redir valid=%b en=%b expected 0,0", valid, ram_en);
    else passed++;
    tick();
    #1;
    checks++;
    if (valid !== 1'b1 || ram_en !== 1'b0 || ram_addr !== 32'h1c00_0300)
      $display("FAIL b2b_target valid=%b en=%b addr=%h expected 1,0,1c000300", valid, ram_en, ram_addr);
    else passed++;
    allow_in = 1'b1;
    exp_q.push_back(32'h1c00_0300);
    tick();
  endtask

  task automatic test_misaligned_wrap();
    id_bus = {1'b1, 32'h1c00_0107};
    tick();
    id_bus = '0;
    tick();
    exp_q.push_back(32'h1c00_0104);
    #1;
    checks++;
    if (ram_addr !== 32'h1c00_0104 || if_bus[95:64] !== 32'h1c00_0108)
      $display("FAIL misaligned addr=%h pred=%h expected 1c000104,1c000108", ram_addr, if_bus[95:64]);
    else passed++;
    tick();
    id_bus = {1'b1, 32'hffff_fffc};
    tick();
    id_bus = '0;
    tick();
    exp_q.push_back(32'hffff_fffc);
    #1;
    checks++;
    if (ram_addr !== 32'hffff_fffc || if_bus[95:64] !== 32'h0000_0000)
      $display("FAIL wrap_pred addr=%h pred=%h expected fffffffc,00000000", ram_addr, if_bus[95:64]);
    else passed++;
    tick();
    exp_q.push_back(32'h0000_0000);
    #1;
    checks++;
    if (ram_addr !== 32'h0000_0000 || if_bus[95:64] !== 32'h0000_0004)
      $display("FAIL wrap_next addr=%h pred=%h expected 00000000,00000004", ram_addr, if_bus[95:64]);
    else passed++;
    tick();
  endtask

  task automatic test_counters();
    // mid-operation reset clears everything, then 10 fires and 2 cancels
    reset = 1'b0; allow_in = 1'b0;
    tick();
    #1;
    checks++;
    if (valid !== 1'b0 || ram_addr !== RPC || fetch_cnt !== 32'd0 || redirect_cnt !== 32'd0)
      $display("FAIL midrun_reset valid=%b addr=%h fc=%0d rc=%0d expected 0,%h,0,0",
               valid, ram_addr, fetch_cnt, redirect_cnt, RPC);
    else passed++;
    reset = 1'b1;
    tick();
    allow_in = 1'b1;
    fire_run(RPC, 3);
    id_bus = {1'b1, 32'h1c00_0040};
    tick();
    id_bus = '0;
    tick();
    fire_run(32'h1c00_0040, 3);
    id_bus = {1'b1, 32'h1c00_0080};
    tick();
    id_bus = '0;
    tick();
    fire_run(32'h1c00_0080, 4);
    allow_in = 1'b0;
    #1;
    checks++;
    if (fetch_cnt !== 32'(PERF) * 32'd10 || redirect_cnt !== 32'(PERF) * 32'd2)
      $display("FAIL counters fc=%0d rc=%0d expected %0d,%0d",
               fetch_cnt, redirect_cnt, 32'(PERF) * 32'd10, 32'(PERF) * 32'd2);
    else passed++;
    tick();
  endtask

  initial begin
    reset = 1'b0; allow_in = 1'b0; id_bus = '0;
    test_reset();
    test_stall();
    test_redirect();
    test_cancel_stall_back_to_back();
    test_misaligned_wrap();
    test_counters();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) $display("FAIL missing_fires pending=%0d expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_ifetch_stage
`default_nettype wire
